// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared AES-128 key-schedule constants and helpers.
//   NR / NR_IDX  : number of rounds (10) as an integer and as a 4-bit index
//   state_e      : key-stream controller states
//   rcon()       : round constant for rounds 1..10 (0 elsewhere)
//   word()       : slice word 0..3 out of a 128-bit key (w0 = [127:96])
//   sbox()       : AES forward S-box (GF(2^8) inverse + affine map)
package aes_key_pkg;

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned NR     = 10;
  localparam logic [3:0]  NR_IDX = 4'(NR);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    STREAM
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] word(input logic [KEY_W-1:0] k, input int unsigned i);
    return k[32*(3-i) +: 32];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] e;
    logic [7:0] r;
    logic [7:0] base;
    e    = 8'd254;
    r    = 8'h01;
    base = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: AES SubWord, four parallel forward S-boxes (combinational).
//   word_i : 32-bit input word
//   word_o : 32-bit substituted word
module aes_sub_word
  import aes_key_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
  end

endmodule

// File: rtl/inv_key_stream.sv
// inv_key_stream: AES-128 round keys delivered in decryption order (10..0).
// Expands the cipher key forward for 10 cycles, then walks the schedule
// backwards one round per accepted transfer.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load key_in (honoured only when idle)
//   key_in     : cipher key, w0 = [127:96]
//   busy       : expanding or streaming
//   key_valid  : round_key / round_idx valid
//   key_ready  : consumer accept
//   round_key  : current round key
//   round_idx  : round number of round_key
//   last       : valid key is round 0
module inv_key_stream
  import aes_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             last
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       rnd_q, rnd_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv_w3;
  logic [31:0] sub_in, sub_out, rc_word;
  logic [31:0] f0, f1, f2, f3;
  logic        hs;

  assign w0 = word(key_q, 0);
  assign w1 = word(key_q, 1);
  assign w2 = word(key_q, 2);
  assign w3 = word(key_q, 3);

  // Inverse step recovers the previous round's last word first; it is
  // what feeds the shared SubWord, just as w3 does going forward.
  assign inv_w3  = w3 ^ w2;
  assign sub_in  = (state_q == STREAM) ? inv_w3 : w3;
  assign rc_word = {rcon(rnd_q), 24'h0};

  aes_sub_word u_sub_word (
    .word_i ({sub_in[23:0], sub_in[31:24]}),
    .word_o (sub_out)
  );

  assign f0 = w0 ^ sub_out ^ rc_word;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign hs = (state_q == STREAM) && key_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXPAND;
          key_d   = key_in;
          rnd_d   = 4'd1;
        end
      end
      EXPAND: begin
        key_d = {f0, f1, f2, f3};
        if (rnd_q == NR_IDX) begin
          state_d = STREAM;
          rnd_d   = NR_IDX;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      STREAM: begin
        if (hs) begin
          if (rnd_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            key_d = {w0 ^ sub_out ^ rc_word, w1 ^ w0, w2 ^ w1, inv_w3};
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    key_valid = (state_q == STREAM);
    last      = (state_q == STREAM) && (rnd_q == 4'd0);
    round_key = key_q;
    round_idx = rnd_q;
  end

endmodule

// File: tb/tb_inv_key_stream.sv
module tb_inv_key_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         last;

  int errors = 0;
  int checks = 0;

  logic [127:0] model_rk [0:10];
  logic [127:0] cap      [0:10];

  always #5 clk = ~clk;

  inv_key_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .last      (last)
  );

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  // ---------------- reference model (plain FIPS-197 expansion) ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_valid"}, 128'(key_valid), 128'd0);
    chk({tag, "_last"}, 128'(last), 128'd0);
    chk({tag, "_key"}, round_key, 128'd0);
    chk({tag, "_idx"}, 128'(round_idx), 128'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Load key, expand, stream all keys (or stop when stop_idx is presented).
  task automatic run_seq(input logic [127:0] key, input bit rand_ready,
                         input bit pulse_start, input int stop_idx, output bit stopped);
    int           cnt;
    int           hs;
    int           exp_idx;
    int           guard;
    bit           stalled;
    logic [127:0] pk;
    logic [3:0]   pi;
    stopped = 1'b0;
    build_model(key);
    key_ready = 1'b0;
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = rand128();
    chk("busy_after_start", 128'(busy), 128'd1);
    cnt = 1;
    while (!key_valid && cnt < 40) begin
      if (pulse_start && cnt == 5) start = 1'b1;
      tick();
      start = 1'b0;
      cnt++;
    end
    chk("first_valid_latency", 128'(cnt), 128'd11);
    exp_idx = 10;
    hs      = 0;
    stalled = 1'b0;
    pk      = '0;
    pi      = '0;
    guard   = 0;
    while (exp_idx >= 0 && guard < 400) begin
      guard++;
      if (!key_valid) begin
        chk("valid_during_stream", 128'(key_valid), 128'd1);
        break;
      end
      if (stalled) begin
        chk("stall_key_stable", round_key, pk);
        chk("stall_idx_stable", 128'(round_idx), 128'(pi));
      end
      if (stop_idx >= 0 && int'(round_idx) == stop_idx) begin
        stopped = 1'b1;
        return;
      end
      key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse_start && exp_idx == 6) begin
        start  = 1'b1;
        key_in = rand128();
      end
      if (key_ready) begin
        chk("round_idx", 128'(round_idx), 128'(exp_idx));
        chk("round_key", round_key, model_rk[exp_idx]);
        chk("last", 128'(last), 128'(exp_idx == 0));
        cap[exp_idx] = round_key;
        hs++;
        exp_idx--;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pk = round_key;
        pi = round_idx;
      end
      tick();
      start = 1'b0;
    end
    key_ready = 1'b0;
    if (guard >= 400) chk("stream_timeout", 128'(guard), 128'd0);
    chk("handshakes", 128'(hs), 128'd11);
    chk("busy_after_last", 128'(busy), 128'd0);
    chk("valid_after_last", 128'(key_valid), 128'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs [6];
    bit   s;
    logic [127:0] k;

    vecs[0] = '{"fips_idx10", FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{"fips_idx9",  FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[2] = '{"fips_idx1",  FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{"fips_idx0",  FIPS_KEY, 0,  FIPS_KEY};
    vecs[4] = '{"zero_idx10", 128'h0,   10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[5] = '{"zero_idx0",  128'h0,   0,  128'h0};

    rst_n = 1'b0;
    start = 1'b0;
    key_ready = 1'b0;
    key_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_zero("reset");

    // key_ready while idle must not start anything
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("ready_idle_valid", 128'(key_valid), 128'd0);

    // Known-answer table (consecutive runs are also back-to-back starts)
    for (int i = 0; i < 6; i++) begin
      run_seq(vecs[i].key, 1'b0, 1'b0, -1, s);
      chk(vecs[i].name, cap[vecs[i].idx], vecs[i].exp);
    end

    // FIPS key with backpressure and ignored start pulses
    run_seq(FIPS_KEY, 1'b1, 1'b1, -1, s);
    chk("bp_fips_idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("bp_fips_idx1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // Random keys, random backpressure, back-to-back
    for (int i = 0; i < 6; i++) begin
      k = rand128();
      run_seq(k, 1'(i % 2), 1'(i % 3 == 0), -1, s);
    end

    // Reset mid-EXPAND
    key_in = FIPS_KEY;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("rst_expand");
    run_seq(FIPS_KEY, 1'b0, 1'b0, -1, s);
    chk("after_rst_expand_idx9", cap[9], 128'hac7766f319fadc2128d12941575c006e);

    // Reset with idx 5 presented in STREAM
    run_seq(FIPS_KEY, 1'b0, 1'b0, 5, s);
    chk("reached_idx5", 128'(s), 128'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("rst_stream");
    k = rand128();
    run_seq(k, 1'b1, 1'b0, -1, s);
    run_seq(FIPS_KEY, 1'b0, 1'b0, -1, s);
    chk("after_rst_stream_idx0", cap[0], FIPS_KEY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_key_stream.md
# inv_key_stream

Sequential AES-128 key-schedule unit that delivers round keys in decryption order, round 10 down to round 0, to the inverse-cipher datapath. It loads the cipher key and runs the forward schedule iteratively for 10 cycles to reach round key 10. It then walks the schedule backwards one round per accepted transfer using the inverse recurrence, so no 11×128-bit key store is needed. It sits between the key input and the decryption round pipeline, alongside the forward expansion used by encryption.

## Interface
- No parameters. Nr = 10 and the key width of 128 are fixed constants in the package.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `start` input 1: load request, sampled only in IDLE.
- `key_in` input 128: cipher key. Word w0 = [127:96], w3 = [31:0].
- `busy` output 1: high in EXPAND and STREAM.
- `key_valid` output 1: `round_key` / `round_idx` are valid.
- `key_ready` input 1: consumer accepts the key when `key_valid` and `key_ready` are both high.
- `round_key` output 128: current round key, same word order as `key_in`.
- `round_idx` output 4: round number of `round_key`, 10..0.
- `last` output 1: `key_valid` && `round_idx` == 0.

## Operation
- States: IDLE, EXPAND, STREAM. Registers: `key_reg[127:0]`, `rnd[3:0]`.
- IDLE:
  - When `start`=1: `key_reg`<=`key_in`, `rnd`<=1, go to EXPAND.
  - When `start`=0: hold.
- EXPAND: forward step using RCON[`rnd`].
  - t = w0 ^ SubWord(RotWord(w3)) ^ {RCON, 24'h0}; w4 = t; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
  - `key_reg`<={w4..w7}, `rnd`<=`rnd`+1.
  - After the step with `rnd`=10: go to STREAM with `rnd`<=10.
- STREAM: `key_valid`=1, `round_key`=`key_reg`, `round_idx`=`rnd`.
  - On a handshake with `rnd`>0: apply the inverse step with RCON[`rnd`].
    - w3' = w7^w6; w2' = w6^w5; w1' = w5^w4; w0' = w4 ^ SubWord(RotWord(w3')) ^ {RCON, 24'h0}.
    - `rnd`<=`rnd`-1.
  - On a handshake with `rnd`=0: go to IDLE.
  - Without a handshake: `key_reg`, `rnd` and outputs hold, so the interface is stable under backpressure.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36. All XORs are 128-bit, and the 4-bit index never wraps.
- `start` in EXPAND or STREAM is ignored. There is no abort; the only way out mid-sequence is reset.
- Reset (any state, including mid-EXPAND or mid-STREAM):
  - State goes to IDLE.
  - `key_reg`=0, `rnd`=0.
  - `busy`=0, `key_valid`=0, `last`=0, `round_key`=0, `round_idx`=0.
- The forward and inverse steps share one SubWord instance: the forward step feeds it w3, the inverse step feeds it w7^w6.

## Timing
- `start` sampled at edge E0: EXPAND occupies cycles E0+1..E0+10, and `key_valid` rises after edge E0+11. Start-to-first-key latency is 11 cycles.
- `key_valid` is low in IDLE and EXPAND. `busy` rises the cycle after `start`.
- With `key_ready` held high, all 11 keys (idx 10..0) are delivered on 11 consecutive cycles.
- After the idx-0 handshake: `key_valid` and `busy` are low the next cycle, and a new `start` is accepted in that cycle.
- `key_ready` while `key_valid`=0 has no effect.
- All outputs are registered or decoded only from state/registers. There is no combinational path from `key_ready` or `start` to any output.

## Structure
- Package `aes_key_pkg`:
  - NR = 10.
  - RCON table indexed 1..10.
  - State enum {IDLE, EXPAND, STREAM}.
  - Word-slicing helpers for w0..w3.
- Sub-module `aes_sub_word`: combinational, 32-bit in/out, four instances of the codebase's AES forward S-box. One instance per `inv_key_stream`.
- Everything else (FSM, forward/inverse step muxing) lives in `inv_key_stream`.

## Test plan
- FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, `start`, `key_ready`=1.
  - First valid is 11 cycles after `start`, with idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - idx 9 = ac7766f319fadc2128d12941575c006e.
  - idx 1 = a0fafe1788542cb123a339392a6c7605.
  - idx 0 = `key_in` with `last`=1.
  - `busy`=0 the cycle after.
- All-zero key: idx 10 = b4ef5bcb3e92e21123e951cf6f8f188e; idx 0 = 0.
- Backpressure: random `key_ready`.
  - `round_key` and `round_idx` stay stable while stalled.
  - The sequence is identical to the first scenario, with exactly 11 handshakes.
- `start` pulsed during EXPAND and during STREAM: ignored, and the output sequence is unchanged.
- `rst_n` low for 1 cycle mid-EXPAND, and again with idx=5 in STREAM: all outputs are 0 the next cycle, and a subsequent `start` yields the full correct sequence.
- Back-to-back runs: `start` in the cycle after the idx-0 handshake with a new key gives the correct keys for the new key and nothing carried over from the old one.
